// File: rtl/ring_osc_pkg.sv
// Shared definitions for the ring-oscillator measurement block.
package ring_osc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StCapture
    } meas_state_e;

    localparam int unsigned DefCntW  = 16;
    localparam int unsigned DefGateW = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/osc_edge_counter.sv
// Saturating rising-edge counter clocked by the ring oscillator output.
module osc_edge_counter
    import ring_osc_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             osc,
    input  logic             clr_n,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    always_ff @(posedge osc or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (count == '1) begin
            ovf <= 1'b1;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Sequences one gated ring-oscillator edge count and latches it into the clk domain.
module ring_osc_meas_ctrl
    import ring_osc_pkg::*;
#(
    parameter int unsigned CNT_W        = DefCntW,
    parameter int unsigned GATE_W       = DefGateW,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              osc,
    output logic              ring_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  result,
    output logic              result_ovf
);

    localparam int unsigned TmrW = max_u(GATE_W, $clog2(DRAIN_CYCLES + 1));
    localparam logic [TmrW-1:0] DrainLoad = TmrW'(DRAIN_CYCLES);
    localparam logic [TmrW-1:0] TmrOne    = TmrW'(1);

    meas_state_e       state_q, state_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic              capture;
    logic              ring_en_q, cnt_clr_n_q, done_q;
    logic [CNT_W-1:0]  result_q, cnt;
    logic              ovf_q, cnt_ovf;

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .osc   (osc),
        .clr_n (cnt_clr_n_q),
        .count (cnt),
        .ovf   (cnt_ovf)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        gate_d  = gate_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gate_d  = gate_len;
                    state_d = StClear;
                end
            end
            StClear: begin
                if (gate_q == '0) begin
                    state_d = StDrain;
                    tmr_d   = DrainLoad;
                end else begin
                    state_d = StRun;
                    tmr_d   = TmrW'(gate_q);
                end
            end
            StRun: begin
                if (tmr_q == TmrOne) begin
                    state_d = StDrain;
                    tmr_d   = DrainLoad;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StDrain: begin
                if (tmr_q == TmrOne) begin
                    state_d = StCapture;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StCapture: begin
                state_d = StIdle;
                capture = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over start and over the end-of-gate transition.
        if (abort && (state_q inside {StClear, StRun, StDrain})) begin
            state_d = StIdle;
        end
    end

    // ring_en and the counter clear are registered so they never glitch into the osc domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            gate_q      <= '0;
            ring_en_q   <= 1'b0;
            cnt_clr_n_q <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            gate_q      <= gate_d;
            ring_en_q   <= (state_d == StRun);
            cnt_clr_n_q <= (state_d != StIdle);
            done_q      <= capture;
            if (capture) begin
                result_q <= cnt;
                ovf_q    <= cnt_ovf;
            end
        end
    end

    assign ring_en    = ring_en_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign result     = result_q;
    assign result_ovf = ovf_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Bench for ring_osc_meas_ctrl with a behavioural ring oscillator at four edges per clk.
module tb_ring_osc_meas_ctrl;

    localparam int unsigned CntW  = 8;
    localparam int unsigned GateW = 8;
    localparam int unsigned Drain = 3;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [GateW-1:0] gate_len = '0;
    logic             osc = 1'b1;
    logic             ring_en, busy, done, result_ovf;
    logic [CntW-1:0]  result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int gate;
        int rmin;
        int rmax;
        bit ovf;
    } vec_t;

    typedef struct {
        int rmin;
        int rmax;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    ring_osc_meas_ctrl #(
        .CNT_W        (CntW),
        .GATE_W       (GateW),
        .DRAIN_CYCLES (Drain)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .gate_len   (gate_len),
        .osc        (osc),
        .ring_en    (ring_en),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_ovf (result_ovf)
    );

    always #20 clk = ~clk;

    // Ring model: held high while disabled, period 10 (clk/4) while enabled.
    always begin
        @(posedge ring_en);
        #1;
        while (ring_en) begin
            #5;
            if (ring_en) osc = ~osc;
            else osc = 1'b1;
        end
        osc = 1'b1;
    end

    task automatic check(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (nrst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0, 0);
            end else begin
                e = sb.pop_front();
                check("result", int'(result), e.rmin, e.rmax);
                check("result_ovf", int'(result_ovf), int'(e.ovf), int'(e.ovf));
            end
        end
    end

    // Sample j is taken after clk edge j (edge 0 accepts start).
    task automatic run_meas(input int g, input int rmin, input int rmax, input bit ovf,
                            input int mid_pulse_j);
        int en_cnt = 0;
        int lat = -1;
        int dones = 0;
        @(negedge clk);
        gate_len = GateW'(g);
        start = 1'b1;
        sb.push_back('{rmin, rmax, ovf});
        for (int j = 0; j < g + int'(Drain) + 40; j++) begin
            @(negedge clk);
            start = (j == mid_pulse_j);
            if (j == 0) check("busy_after_accept", int'(busy), 1, 1);
            if (ring_en) en_cnt++;
            if (done) begin
                dones++;
                if (lat < 0) lat = j + 1;
            end
        end
        start = 1'b0;
        check("ring_en_cycles", en_cnt, g, g);
        check("done_latency", lat, g + int'(Drain) + 3, g + int'(Drain) + 3);
        check("done_count", dones, 1, 1);
        check("idle_after_run", int'(busy), 0, 0);
    endtask

    initial begin
        int dones;
        int last;

        vecs[0] = '{10, 39, 41, 1'b0};
        vecs[1] = '{100, 255, 255, 1'b1};
        vecs[2] = '{10, 39, 41, 1'b0};
        vecs[3] = '{0, 0, 0, 1'b0};
        vecs[4] = '{1, 3, 5, 1'b0};
        vecs[5] = '{3, 11, 13, 1'b0};
        vecs[6] = '{255, 255, 255, 1'b1};

        #5;
        check("rst_ring_en", int'(ring_en), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_done", int'(done), 0, 0);
        check("rst_result", int'(result), 0, 0);
        check("rst_ovf", int'(result_ovf), 0, 0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // First vector also pulses start again mid-RUN, which must be ignored.
        for (int i = 0; i < 7; i++) begin
            run_meas(vecs[i].gate, vecs[i].rmin, vecs[i].rmax, vecs[i].ovf, (i == 0) ? 4 : -1);
        end

        // start held high: back-to-back runs, one per IDLE visit, every g+6 cycles.
        @(negedge clk);
        gate_len = GateW'(5);
        start = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('{19, 21, 1'b0});
        dones = 0;
        last = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                last = j;
                if (dones == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held_start_dones", dones, 3, 3);
        check("held_start_last_done", last, 32, 32);
        check("held_start_idle", int'(busy), 0, 0);

        // Abort at RUN cycle 4 of 10: no done, previous result kept.
        @(negedge clk);
        gate_len = GateW'(10);
        start = 1'b1;
        dones = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 4) begin
                check("abort_ring_running", int'(ring_en), 1, 1);
                abort = 1'b1;
            end
            if (j == 5) begin
                abort = 1'b0;
                check("abort_ring_en", int'(ring_en), 0, 0);
                check("abort_busy", int'(busy), 0, 0);
            end
            if (done) dones++;
        end
        check("abort_no_done", dones, 0, 0);
        check("abort_result_kept", int'(result), 19, 21);
        check("abort_ovf_kept", int'(result_ovf), 0, 0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        gate_len = GateW'(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_ring_en", int'(ring_en), 1, 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_ring_en", int'(ring_en), 0, 0);
        check("mid_rst_busy", int'(busy), 0, 0);
        check("mid_rst_result", int'(result), 0, 0);
        check("mid_rst_done", int'(done), 0, 0);
        @(negedge clk);
        nrst = 1'b1;
        run_meas(10, 39, 41, 1'b0, -1);

        check("scoreboard_empty", sb.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
